csr_exec_unit: RTL

//  Execution unit for Zicsr ops (CSRRW/RS/RC and immediate forms) issued from the CSR reservation station.

---
 rtl/csr_pkg.sv | 28 ++
 rtl/csr_alu.sv | 41 ++++
 rtl/csr_exec_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared constants, state encoding and CSR address legality helper for the CSR execution unit.
package csr_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [11:0] CSR_WRITE = 12'h000;
  localparam logic [11:0] CSR_CAUSE = 12'h001;
  localparam logic [11:0] CSR_EPC   = 12'h002;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_COMMIT = 2'd1,
    WRITE       = 2'd2,
    BCAST       = 2'd3
  } state_e;

  // Writable only if not in the read-only space and actually implemented.
  function automatic logic csr_addr_legal(input logic [11:0] addr);
    return (addr[11:10] != 2'b11) &&
           ((addr == CSR_WRITE) || (addr == CSR_CAUSE) || (addr == CSR_EPC));
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational Zicsr new-value and write-enable computation.
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [4:0]      zimm_i,
  input  logic            rs1_zero_i,
  output logic [XLEN-1:0] new_val_o,
  output logic            we_o
);

  logic [XLEN-1:0] src;
  logic            src_zero;

  always_comb begin
    src       = funct3_i[2] ? XLEN'(zimm_i) : rs1_val_i;
    src_zero  = funct3_i[2] ? (zimm_i == 5'd0) : rs1_zero_i;
    new_val_o = old_i;
    we_o      = 1'b0;
    case (funct3_i)
      F3_RW, F3_RWI: begin
        new_val_o = src;
        we_o      = 1'b1;
      end
      F3_RS, F3_RSI: begin
        new_val_o = old_i | src;
        we_o      = !src_zero;
      end
      F3_RC, F3_RCI: begin
        new_val_o = old_i & ~src;
        we_o      = !src_zero;
      end
      default: ; // 000/100: no write, old value still broadcast
    endcase
  end

endmodule

// File: rtl/csr_exec_unit.sv
// Zicsr execution unit: holds one op until ROB commit, writes the CSR file, then returns the old value on the CDB.
// Optional feature: define CSR_ILLEGAL_CHECK_EN to reject writes to read-only/unimplemented CSRs.
module csr_exec_unit
  import csr_pkg::*;
#(
  parameter int unsigned TAG_W = 6,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [2:0]       issue_funct3,
  input  logic [11:0]      issue_csr_addr,
  input  logic [XLEN-1:0]  issue_csr_old,
  input  logic [XLEN-1:0]  issue_rs1_val,
  input  logic [4:0]       issue_zimm,
  input  logic             issue_rs1_zero,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [TAG_W-1:0] rob_head_tag,
  input  logic             rob_head_valid,
  input  logic             flush,
  output logic             csr_done,
  output logic [XLEN-1:0]  csr_result,
  output logic [11:0]      csr_wr_addr,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_value,
  output logic             illegal_sig
);

  state_e           state_q;
  logic             ready_q;
  logic [2:0]       funct3_q;
  logic [11:0]      addr_q;
  logic [XLEN-1:0]  old_q;
  logic [XLEN-1:0]  rs1_q;
  logic [4:0]       zimm_q;
  logic             rs1_zero_q;
  logic [TAG_W-1:0] tag_q;
  logic             done_q;
  logic [XLEN-1:0]  result_q;
  logic [11:0]      wr_addr_q;
  logic             cdb_req_q;
  logic [TAG_W-1:0] cdb_tag_q;
  logic [XLEN-1:0]  cdb_value_q;
  logic [XLEN-1:0]  alu_new;
  logic             alu_we;
  logic             head_match;
`ifdef CSR_ILLEGAL_CHECK_EN
  logic             illegal_q;
`endif

  csr_alu #(.XLEN(XLEN)) u_alu (
    .funct3_i   (funct3_q),
    .old_i      (old_q),
    .rs1_val_i  (rs1_q),
    .zimm_i     (zimm_q),
    .rs1_zero_i (rs1_zero_q),
    .new_val_o  (alu_new),
    .we_o       (alu_we)
  );

  assign head_match = rob_head_valid && (rob_head_tag == tag_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      funct3_q    <= 3'd0;
      addr_q      <= 12'd0;
      old_q       <= '0;
      rs1_q       <= '0;
      zimm_q      <= 5'd0;
      rs1_zero_q  <= 1'b0;
      tag_q       <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      wr_addr_q   <= 12'd0;
      cdb_req_q   <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
`ifdef CSR_ILLEGAL_CHECK_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef CSR_ILLEGAL_CHECK_EN
      illegal_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (issue_valid && ready_q && !flush) begin
            funct3_q   <= issue_funct3;
            addr_q     <= issue_csr_addr;
            old_q      <= issue_csr_old;
            rs1_q      <= issue_rs1_val;
            zimm_q     <= issue_zimm;
            rs1_zero_q <= issue_rs1_zero;
            tag_q      <= issue_tag;
            ready_q    <= 1'b0;
            state_q    <= WAIT_COMMIT;
          end
        end
        WAIT_COMMIT: begin
          // Flush wins over a same-cycle commit match.
          if (flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else if (head_match) begin
            state_q <= WRITE;
            if (alu_we) begin
`ifdef CSR_ILLEGAL_CHECK_EN
              if (csr_addr_legal(addr_q)) begin
                done_q    <= 1'b1;
                result_q  <= alu_new;
                wr_addr_q <= addr_q;
              end else begin
                illegal_q <= 1'b1;
              end
`else
              done_q    <= 1'b1;
              result_q  <= alu_new;
              wr_addr_q <= addr_q;
`endif
            end
          end
        end
        WRITE: begin
`ifdef CSR_ILLEGAL_CHECK_EN
          if (illegal_q) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
`else
          begin
`endif
            cdb_req_q   <= 1'b1;
            cdb_tag_q   <= tag_q;
            cdb_value_q <= old_q;
            state_q     <= BCAST;
          end
        end
        BCAST: begin
          if (cdb_grant) begin
            cdb_req_q <= 1'b0;
            state_q   <= IDLE;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign issue_ready = ready_q;
  assign csr_done    = done_q;
  assign csr_result  = result_q;
  assign csr_wr_addr = wr_addr_q;
  assign cdb_req     = cdb_req_q;
  assign cdb_tag     = cdb_tag_q;
  assign cdb_value   = cdb_value_q;
`ifdef CSR_ILLEGAL_CHECK_EN
  assign illegal_sig = illegal_q;
`else
  assign illegal_sig = 1'b0;
`endif

endmodule
